vector_alu_seq: RTL

VECTOR_ALU_SEQ -- requirements
Module: vector_alu_seq

---
 rtl/vector_alu_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vector_alu_seq.sv
// Sequential vector ALU: one element per cycle over up to MAX_N elements,
// with a DOT reduction into result[0] and an error flag for unknown opcodes.
module vector_alu_seq #(
    parameter int MAX_N = 128,
    parameter int W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         opcode,
    input  logic [31:0]        n,
    input  logic [MAX_N*W-1:0] a,
    input  logic [MAX_N*W-1:0] b,
    output logic [MAX_N*W-1:0] result,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int IW = $clog2(MAX_N + 1);

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_SUB = 8'h01;
    localparam logic [7:0] OP_AND = 8'h02;
    localparam logic [7:0] OP_OR  = 8'h03;
    localparam logic [7:0] OP_XOR = 8'h04;
    localparam logic [7:0] OP_MUL = 8'h05;
    localparam logic [7:0] OP_DOT = 8'h06;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         op_q, op_d;
    logic [IW-1:0]      n_q, n_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [MAX_N*W-1:0] result_q, result_d;
    logic               err_q, err_d;
    logic [MAX_N*W-1:0] a_q, b_q;

    logic               accept;
    logic               supported;
    logic [IW-1:0]      n_eff;
    logic [W-1:0]       a_el, b_el, prod, elem;

    assign accept    = (state_q == IDLE) && start;
    assign supported = (opcode <= OP_DOT);
    assign n_eff     = (n > 32'(MAX_N)) ? IW'(MAX_N) : n[IW-1:0];

    assign a_el = a_q[int'(idx_q)*W +: W];
    assign b_el = b_q[int'(idx_q)*W +: W];
    assign prod = a_el * b_el;

    always_comb begin
        unique case (op_q)
            OP_ADD:  elem = a_el + b_el;
            OP_SUB:  elem = a_el - b_el;
            OP_AND:  elem = a_el & b_el;
            OP_OR:   elem = a_el | b_el;
            OP_XOR:  elem = a_el ^ b_el;
            OP_MUL:  elem = prod;
            default: elem = '0;
        endcase
    end

    // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        n_d      = n_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = opcode;
                    n_d      = n_eff;
                    idx_d    = '0;
                    acc_d    = '0;
                    result_d = '0;
                    err_d    = !supported;
                    state_d  = (!supported || n_eff == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (op_q == OP_DOT) begin
                    acc_d              = acc_q + prod;
                    result_d[W-1:0]    = acc_d;
                end else begin
                    result_d[int'(idx_q)*W +: W] = elem;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == n_q - 1'b1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            n_q      <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // NOTE: operand snapshots carry no reset; they are always loaded before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    assign result = result_q;
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign err    = (state_q == DONE) && err_q;

endmodule
